// File: rtl/aspida_seq_pkg.sv
// ---------------------------------------------------------------------------
// aspida_seq_pkg
// Shared definitions for the phase sequencer and its delay-chain loader:
// FSM state encoding, vector/counter widths and the phase-length helper.
// No ports (package).
// ---------------------------------------------------------------------------
package aspida_seq_pkg;

    localparam int DEL_VEC_W  = 11;
    localparam int PAIR_CNT_W = 16;
    localparam int CFG_W      = 8;
    localparam int BIT_CNT_W  = $clog2(DEL_VEC_W);

    // Index of the last bit shifted out (bit 0 of the captured vector).
    localparam logic [BIT_CNT_W-1:0] SHIFT_LAST_BIT = BIT_CNT_W'(DEL_VEC_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_G1   = 3'd3,
        ST_GAP  = 3'd4,
        ST_G2   = 3'd5
    } state_t;

    // A phase of length L occupies L cycles, so the down-counter is loaded
    // with L-1 and the state exits when it reaches 0. Length 0 means 1.
    function automatic logic [CFG_W-1:0] len_to_cnt(input logic [CFG_W-1:0] len);
        return (len == '0) ? '0 : len - CFG_W'(1);
    endfunction

endpackage

// File: rtl/aspida_del_shifter.sv
// ---------------------------------------------------------------------------
// aspida_del_shifter
// Serial loader for the controller delay chain. On start it captures the
// delay-select vector and shifts it out MSB first, two clocks per bit:
// data changes while shift_clk is low and is held through shift_clk high.
// A full load takes 2*DEL_VEC_W cycles; done marks the final cycle.
//
// Ports:
//   clk, reset       - system clock, synchronous active-high reset
//   start            - one-cycle pulse, captures vector and begins a load
//   vector           - delay-select vector to shift out
//   done             - high during the last cycle of a load (combinational)
//   scan_en          - registered, high for the whole load
//   scan_in          - registered serial data, 0 when idle
//   shift_clk        - registered shift clock for the delay chain
// ---------------------------------------------------------------------------
module aspida_del_shifter
    import aspida_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DEL_VEC_W-1:0] vector,
    output logic                 done,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 shift_clk
);

    logic [DEL_VEC_W-1:0] shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;

    assign done = scan_en & shift_clk & (bit_cnt == SHIFT_LAST_BIT);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            scan_en   <= 1'b0;
            scan_in   <= 1'b0;
            shift_clk <= 1'b0;
        end else if (start) begin
            // MSB goes straight to scan_in; the rest waits in shreg.
            shreg     <= vector << 1;
            bit_cnt   <= '0;
            scan_en   <= 1'b1;
            scan_in   <= vector[DEL_VEC_W-1];
            shift_clk <= 1'b0;
        end else if (scan_en) begin
            if (!shift_clk) begin
                shift_clk <= 1'b1;
            end else if (bit_cnt == SHIFT_LAST_BIT) begin
                scan_en   <= 1'b0;
                scan_in   <= 1'b0;
                shift_clk <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                shift_clk <= 1'b0;
                scan_in   <= shreg[DEL_VEC_W-1];
                shreg     <= shreg << 1;
                bit_cnt   <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aspida_phase_seq.sv
// ---------------------------------------------------------------------------
// aspida_phase_seq
// Two-phase pulse sequencer. While run is high (and halt low) it issues
// back-to-back pairs: WAIT (cfg_idle), G1 pulse (cfg_g1), GAP (cfg_gap),
// G2 pulse (cfg_g2). A started pulse always completes; only WAIT can be
// aborted. In IDLE a del_load pulse serially loads del_vector into the
// controller delay chain through aspida_del_shifter.
//
// Optional feature (macro ASPIDA_PHASE_SEQ_STEP_EN): adds input step; a step
// pulse in IDLE runs exactly one pair and returns to IDLE regardless of run.
//
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   run, halt                      - level controls for pair issue
//   cfg_idle/g1/gap/g2 [7:0]       - phase lengths in cycles (0 acts as 1)
//   del_vector [10:0], del_load    - delay-chain vector and load request
//   step (optional)                - single-pair request
//   global_g1, global_g2           - registered non-overlapping pulses
//   del_scan_en/scan_in/shift_clk  - registered serial load interface
//   busy                           - registered, high outside IDLE
//   pair_cnt [15:0]                - registered count of completed pairs
// ---------------------------------------------------------------------------
module aspida_phase_seq
    import aspida_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  halt,
    input  logic [CFG_W-1:0]      cfg_idle,
    input  logic [CFG_W-1:0]      cfg_g1,
    input  logic [CFG_W-1:0]      cfg_gap,
    input  logic [CFG_W-1:0]      cfg_g2,
    input  logic [DEL_VEC_W-1:0]  del_vector,
    input  logic                  del_load,
`ifdef ASPIDA_PHASE_SEQ_STEP_EN
    input  logic                  step,
`endif
    output logic                  global_g1,
    output logic                  global_g2,
    output logic                  del_scan_en,
    output logic                  del_scan_in,
    output logic                  del_shift_clk,
    output logic                  busy,
    output logic [PAIR_CNT_W-1:0] pair_cnt
);

    state_t           state, next_state;
    logic [CFG_W-1:0] cnt, entry_cnt;
    logic [CFG_W-1:0] len_g1, len_gap, len_g2;
    logic             go, abort, shift_start, shift_done, pair_done;
    logic             step_req, step_mode;

    assign go = run & ~halt;

`ifdef ASPIDA_PHASE_SEQ_STEP_EN
    logic step_mode_q;
    assign step_req  = step;
    assign step_mode = step_mode_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_mode_q <= 1'b0;
        end else if (state == ST_IDLE && next_state == ST_WAIT) begin
            step_mode_q <= step_req;
        end else if (next_state == ST_IDLE) begin
            step_mode_q <= 1'b0;
        end
    end
`else
    assign step_req  = 1'b0;
    assign step_mode = 1'b0;
`endif

    // A stepped pair ignores run but still honours halt while in WAIT.
    assign abort = step_mode ? halt : ~go;

    // NOTE: every variable driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        shift_start = 1'b0;
        pair_done   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (del_load) begin
                    next_state  = ST_LOAD;
                    shift_start = 1'b1;
                end else if (go || step_req) begin
                    next_state = ST_WAIT;
                end
            end
            ST_LOAD: if (shift_done) next_state = ST_IDLE;
            ST_WAIT: begin
                if (abort)           next_state = ST_IDLE;
                else if (cnt == '0)  next_state = ST_G1;
            end
            ST_G1:   if (cnt == '0) next_state = ST_GAP;
            ST_GAP:  if (cnt == '0) next_state = ST_G2;
            ST_G2: begin
                if (cnt == '0) begin
                    pair_done  = 1'b1;
                    next_state = (go && !step_mode) ? ST_WAIT : ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Counter value for the state being entered. WAIT reads cfg_idle live
    // (it is sampled on this very edge); later phases use the shadow copies.
    always_comb begin
        entry_cnt = '0;
        case (next_state)
            ST_WAIT: entry_cnt = len_to_cnt(cfg_idle);
            ST_G1:   entry_cnt = len_to_cnt(len_g1);
            ST_GAP:  entry_cnt = len_to_cnt(len_gap);
            ST_G2:   entry_cnt = len_to_cnt(len_g2);
            default: entry_cnt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            len_g1    <= '0;
            len_gap   <= '0;
            len_g2    <= '0;
            pair_cnt  <= '0;
            global_g1 <= 1'b0;
            global_g2 <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= next_state;

            // No state re-enters itself, so a state change marks an entry.
            if (next_state != state) begin
                cnt <= entry_cnt;
            end else if (cnt != '0) begin
                cnt <= cnt - CFG_W'(1);
            end

            // Freeze the pair's lengths at WAIT entry so mid-pair cfg edits
            // only take effect on the following pair.
            if (next_state == ST_WAIT && state != ST_WAIT) begin
                len_g1  <= cfg_g1;
                len_gap <= cfg_gap;
                len_g2  <= cfg_g2;
            end

            if (pair_done) begin
                pair_cnt <= pair_cnt + 1'b1;
            end

            // Outputs are decoded from next_state so they line up with the
            // registered state yet come straight from flops.
            global_g1 <= (next_state == ST_G1);
            global_g2 <= (next_state == ST_G2);
            busy      <= (next_state != ST_IDLE);
        end
    end

    aspida_del_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .start     (shift_start),
        .vector    (del_vector),
        .done      (shift_done),
        .scan_en   (del_scan_en),
        .scan_in   (del_scan_in),
        .shift_clk (del_shift_clk)
    );

endmodule

// File: tb/tb_aspida_phase_seq.sv
// ---------------------------------------------------------------------------
// tb_aspida_phase_seq
// Self-checking bench for aspida_phase_seq. Expected pair timings are pushed
// to a scoreboard queue when a pair is requested; a negedge monitor measures
// WAIT/G1/GAP/G2 lengths and pair_cnt and pops/compares at each pair end.
// Define ASPIDA_PHASE_SEQ_STEP_EN to also exercise the single-step feature.
// ---------------------------------------------------------------------------
module tb_aspida_phase_seq;
    import aspida_seq_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  run;
    logic                  halt;
    logic [7:0]            cfg_idle, cfg_g1, cfg_gap, cfg_g2;
    logic [DEL_VEC_W-1:0]  del_vector;
    logic                  del_load;
`ifdef ASPIDA_PHASE_SEQ_STEP_EN
    logic                  step;
`endif
    logic                  global_g1, global_g2;
    logic                  del_scan_en, del_scan_in, del_shift_clk;
    logic                  busy;
    logic [PAIR_CNT_W-1:0] pair_cnt;

    aspida_phase_seq dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .halt          (halt),
        .cfg_idle      (cfg_idle),
        .cfg_g1        (cfg_g1),
        .cfg_gap       (cfg_gap),
        .cfg_g2        (cfg_g2),
        .del_vector    (del_vector),
        .del_load      (del_load),
`ifdef ASPIDA_PHASE_SEQ_STEP_EN
        .step          (step),
`endif
        .global_g1     (global_g1),
        .global_g2     (global_g2),
        .del_scan_en   (del_scan_en),
        .del_scan_in   (del_scan_in),
        .del_shift_clk (del_shift_clk),
        .busy          (busy),
        .pair_cnt      (pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c_idle, c_g1, c_gap, c_g2;
        int         e_wait, e_g1, e_gap, e_g2;
    } vec_t;

    typedef struct {
        int w, a, g, b;
    } exp_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    // monitor state
    int               ph = 0;
    int               nw = 0, n1 = 0, ngap = 0, n3 = 0;
    int               scan_cycles = 0;
    int               g1_cycles = 0;
    logic [PAIR_CNT_W-1:0] model_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int w, input int a, input int g, input int b);
        exp_t e;
        e.w = w; e.a = a; e.g = g; e.b = b;
        sb_q.push_back(e);
    endtask

    // which: 0 = global_g1, 1 = global_g2, other = busy. Ends on a negedge.
    task automatic wait_for(input int which, input logic val, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = (global_g1 == val);
                1:       hit = (global_g2 == val);
                default: hit = (busy == val);
            endcase
        end
        if (!hit) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Pair monitor: measures phase lengths, checks them and pair_cnt on G2 end.
    always @(negedge clk) begin
        if (reset) begin
            ph = 0; nw = 0; n1 = 0; ngap = 0; n3 = 0;
            model_cnt = '0;
        end else begin
            if (del_scan_en) scan_cycles++;
            if (global_g1) g1_cycles++;
            if (global_g1 || global_g2) check("no_overlap", {31'd0, global_g1 & global_g2}, 32'd0);
            if (global_g1) begin
                if (ph != 1) begin ph = 1; n1 = 0; end
                n1++;
            end else if (global_g2) begin
                if (ph != 3) begin ph = 3; n3 = 0; end
                n3++;
            end else begin
                if (ph == 3) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_pair", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("wait_len", nw, e.w);
                        check("g1_len", n1, e.a);
                        check("gap_len", ngap, e.g);
                        check("g2_len", n3, e.b);
                        model_cnt = model_cnt + 1'b1;
                        check("pair_cnt", {16'd0, pair_cnt}, {16'd0, model_cnt});
                    end
                    ph = 0; nw = 0;
                end
                if (ph == 1) begin ph = 2; ngap = 0; end
                if (ph == 2) ngap++;
                else if (busy && !del_scan_en) nw++;
                else nw = 0;
            end
        end
    end

    // Runs n back-to-back pairs with the given vector, then lets run drop
    // during the last pair's G1 so that pair completes and the FSM idles.
    task automatic run_vec(input vec_t v, input int n, input string name);
        tick();
        cfg_idle = v.c_idle; cfg_g1 = v.c_g1; cfg_gap = v.c_gap; cfg_g2 = v.c_g2;
        for (int k = 0; k < n; k++) push_exp(v.e_wait, v.e_g1, v.e_gap, v.e_g2);
        run = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_for(0, 1'b1, 1200, name);
            if (k < n - 1) wait_for(0, 1'b0, 1200, name);
        end
        tick();
        run = 1'b0;
        wait_for(2, 1'b0, 1200, name);
        tick();
        check({name, "_sb_empty"}, sb_q.size(), 32'd0);
    endtask

    task automatic load_check(input logic [DEL_VEC_W-1:0] vec);
        int                   en_cnt = 0;
        int                   nbits  = 0;
        logic                 prev_sclk = 1'b0;
        logic [DEL_VEC_W-1:0] bits = '0;
        tick();
        del_vector = vec;
        del_load   = 1'b1;
        tick();
        del_load   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (del_scan_en) en_cnt++;
            if (del_shift_clk && !prev_sclk) begin
                bits  = {bits[DEL_VEC_W-2:0], del_scan_in};
                nbits++;
            end
            prev_sclk = del_shift_clk;
        end
        check("load_en_cycles", en_cnt, 32'd22);
        check("load_nbits", nbits, 32'd11);
        check("load_bits", {21'd0, bits}, {21'd0, vec});
        check("load_busy_after", {31'd0, busy}, 32'd0);
        check("load_scan_in_after", {31'd0, del_scan_in}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v;
        int   s0, c0;

        vecs[0] = '{8'd2, 8'd3,   8'd1, 8'd3, 2, 3,   1, 3};
        vecs[1] = '{8'd0, 8'd0,   8'd0, 8'd0, 1, 1,   1, 1};
        vecs[2] = '{8'd1, 8'd1,   8'd1, 8'd1, 1, 1,   1, 1};
        vecs[3] = '{8'd5, 8'd2,   8'd4, 8'd1, 5, 2,   4, 1};
        vecs[4] = '{8'd0, 8'd7,   8'd0, 8'd2, 1, 7,   1, 2};
        vecs[5] = '{8'd3, 8'd255, 8'd2, 8'd1, 3, 255, 2, 1};

        reset = 1'b1; run = 1'b0; halt = 1'b0; del_load = 1'b0;
        del_vector = '0; cfg_idle = '0; cfg_g1 = '0; cfg_gap = '0; cfg_g2 = '0;
`ifdef ASPIDA_PHASE_SEQ_STEP_EN
        step = 1'b0;
`endif
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_g1", {31'd0, global_g1}, 32'd0);
        check("rst_g2", {31'd0, global_g2}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_scan", {29'd0, del_scan_en, del_scan_in, del_shift_clk}, 32'd0);
        check("rst_pair_cnt", {16'd0, pair_cnt}, 32'd0);

        // Back-to-back pairs with cfg=(2,3,1,3), then one pair per vector.
        run_vec(vecs[0], 2, "b2b");
        for (int i = 0; i < 6; i++) run_vec(vecs[i], 1, $sformatf("vec%0d", i));

        // cfg edited mid-pair applies to the next pair; del_load while busy is ignored.
        s0 = scan_cycles;
        tick();
        cfg_idle = 8'd2; cfg_g1 = 8'd3; cfg_gap = 8'd1; cfg_g2 = 8'd3;
        push_exp(2, 3, 1, 3);
        run = 1'b1;
        wait_for(0, 1'b1, 50, "cfgchg");
        tick();
        cfg_idle = 8'd1; cfg_g1 = 8'd2; cfg_gap = 8'd2; cfg_g2 = 8'd2;
        push_exp(1, 2, 2, 2);
        del_vector = 11'h7FF;
        del_load = 1'b1;
        tick();
        del_load = 1'b0;
        wait_for(0, 1'b0, 50, "cfgchg");
        wait_for(0, 1'b1, 50, "cfgchg");
        tick();
        run = 1'b0;
        wait_for(2, 1'b0, 50, "cfgchg");
        tick();
        check("cfgchg_sb_empty", sb_q.size(), 32'd0);
        check("load_ignored_busy", scan_cycles - s0, 32'd0);

        // halt in 2nd cycle of G1: pulse completes in full, then IDLE.
        tick();
        cfg_idle = 8'd1; cfg_g1 = 8'd5; cfg_gap = 8'd1; cfg_g2 = 8'd1;
        push_exp(1, 5, 1, 1);
        run = 1'b1;
        wait_for(0, 1'b1, 50, "halt");
        tick();
        halt = 1'b1;
        wait_for(2, 1'b0, 50, "halt");
        tick();
        check("halt_sb_empty", sb_q.size(), 32'd0);
        repeat (5) tick();
        check("halt_stays_idle", {31'd0, busy}, 32'd0);
        halt = 1'b0; run = 1'b0;

        // run dropped during WAIT aborts without a pulse.
        c0 = g1_cycles;
        tick();
        cfg_idle = 8'd10;
        run = 1'b1;
        wait_for(2, 1'b1, 10, "abort");
        tick(); tick();
        run = 1'b0;
        wait_for(2, 1'b0, 5, "abort");
        repeat (12) tick();
        check("abort_no_g1", g1_cycles - c0, 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);

        // Serial load of 11'b10000000001 and a second pattern.
        load_check(11'b10000000001);
        load_check(11'b01101001110);

        // del_load wins over run in IDLE.
        tick();
        del_vector = 11'h555;
        del_load = 1'b1; run = 1'b1;
        tick();
        del_load = 1'b0; run = 1'b0;
        @(negedge clk);
        check("prio_scan_en", {31'd0, del_scan_en}, 32'd1);
        check("prio_no_g1", {31'd0, global_g1}, 32'd0);
        wait_for(2, 1'b0, 30, "prio");

        // Reset in the middle of G2.
        tick();
        cfg_idle = 8'd1; cfg_g1 = 8'd1; cfg_gap = 8'd1; cfg_g2 = 8'd4;
        run = 1'b1;
        wait_for(1, 1'b1, 50, "rst_g2");
        tick();
        reset = 1'b1; run = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_g2", {31'd0, global_g2}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_pair_cnt", {16'd0, pair_cnt}, 32'd0);

        // Wrap at 0xFFFF with all cfg=0 (4-cycle pairs back to back).
        tick();
        force dut.pair_cnt = 16'hFFFF;
        tick();
        release dut.pair_cnt;
        model_cnt = 16'hFFFF;
        run_vec(vecs[1], 2, "wrap");
        check("wrap_final", {16'd0, pair_cnt}, 32'd1);

`ifdef ASPIDA_PHASE_SEQ_STEP_EN
        // A single step pulse runs exactly one pair with run low.
        c0 = g1_cycles;
        tick();
        cfg_idle = 8'd1; cfg_g1 = 8'd2; cfg_gap = 8'd1; cfg_g2 = 8'd2;
        push_exp(1, 2, 1, 2);
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_for(2, 1'b0, 50, "step");
        tick();
        check("step_sb_empty", sb_q.size(), 32'd0);
        repeat (5) tick();
        check("step_idle", {31'd0, busy}, 32'd0);
        check("step_g1_cycles", g1_cycles - c0, 32'd2);
        check("step_pair_cnt", {16'd0, pair_cnt}, 32'd2);
`endif

        repeat (3) tick();
        check("final_sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
